// File: rtl/bidir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bidir_pkg : shared state type and phase-timer constants  rev 1.0 |
// +------------------------------------------------------------------+
package bidir_pkg;

   localparam int CNT_W   = 4;
   localparam int CYC_MIN = 1;
   localparam int CYC_MAX = (1 << CNT_W) - 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TURN_TX = 3'd1,
      ST_DRIVE   = 3'd2,
      ST_TURN_RX = 3'd3,
      ST_SAMPLE  = 3'd4
   } state_t;

   // Out-of-range cycle counts are clamped so the 4-bit timer never wraps.
   function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
      int c;
      c = (cyc < CYC_MIN) ? CYC_MIN : ((cyc > CYC_MAX) ? CYC_MAX : cyc);
      return CNT_W'(c - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bidir_phase_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bidir_phase_timer : shared down-counter for timed phases rev 1.0 |
// +------------------------------------------------------------------+
import bidir_pkg::*;

module bidir_phase_timer (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/bidir_bus_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bidir_bus_sequencer : half-duplex tristate bus sequencer rev 1.0 |
// +------------------------------------------------------------------+
import bidir_pkg::*;

module bidir_bus_sequencer #(
   parameter int WIDTH      = 8,
   parameter int TURN_CYC   = 2,
   parameter int HOLD_CYC   = 3,
   parameter int SAMPLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             io_oe,
   output logic [WIDTH-1:0] io_out,
   input  logic [WIDTH-1:0] io_in,
   output logic             dir_tx,
   output logic             busy
);

   localparam logic [CNT_W-1:0] TURN_LD   = cyc_load(TURN_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD   = cyc_load(HOLD_CYC);
   localparam logic [CNT_W-1:0] SAMPLE_LD = cyc_load(SAMPLE_CYC);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;
   logic [WIDTH-1:0] wdata;

   bidir_phase_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      accept    = cmd_valid & cmd_ready;
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_write) state_nxt = dir_tx ? ST_DRIVE : ST_TURN_TX;
               else           state_nxt = dir_tx ? ST_TURN_RX : ST_SAMPLE;
            end
         end
         ST_TURN_TX: if (tmr_done) state_nxt = ST_DRIVE;
         ST_DRIVE:   if (tmr_done) state_nxt = ST_IDLE;
         ST_TURN_RX: if (tmr_done) state_nxt = ST_SAMPLE;
         ST_SAMPLE:  if (tmr_done) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase

      // Every timed state is entered from a different state, so a change is an entry.
      tmr_load = (state_nxt != state) && (state_nxt != ST_IDLE);
      case (state_nxt)
         ST_DRIVE:  tmr_val = HOLD_LD;
         ST_SAMPLE: tmr_val = SAMPLE_LD;
         default:   tmr_val = TURN_LD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         dir_tx    <= 1'b0;
         io_oe     <= 1'b0;
         io_out    <= '0;
         wdata     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cmd_ready <= (state_nxt == ST_IDLE);
         busy      <= (state_nxt != ST_IDLE);
         rd_valid  <= 1'b0;

         if (accept && cmd_write) wdata <= cmd_data;

         case (state_nxt)
            ST_IDLE: io_oe <= dir_tx;
            ST_DRIVE: begin
               io_oe  <= 1'b1;
               dir_tx <= 1'b1;
               // Same-direction writes go straight from IDLE, before wdata is loaded.
               if (state != ST_DRIVE) io_out <= (state == ST_IDLE) ? cmd_data : wdata;
            end
            ST_TURN_RX: begin
               io_oe  <= 1'b0;
               dir_tx <= 1'b0;
            end
            default: io_oe <= 1'b0;
         endcase

         if (state == ST_SAMPLE && state_nxt == ST_IDLE) begin
            rd_data  <= io_in;
            rd_valid <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bidir_bus_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bidir_bus_sequencer : directed table + random model   rev 1.0 |
// +------------------------------------------------------------------+
module tb_bidir_bus_sequencer;
   import bidir_pkg::*;

   localparam int W  = 8;
   localparam int TC = 2;
   localparam int HC = 3;
   localparam int SC = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_write = 1'b0;
   logic [W-1:0] cmd_data = '0;
   logic [W-1:0] io_in = '0;
   logic         cmd_ready, rd_valid, io_oe, dir_tx, busy;
   logic [W-1:0] rd_data, io_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bidir_bus_sequencer #(
      .WIDTH(W), .TURN_CYC(TC), .HOLD_CYC(HC), .SAMPLE_CYC(SC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_data(cmd_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .io_oe(io_oe), .io_out(io_out), .io_in(io_in),
      .dir_tx(dir_tx), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- directed command table ----------------
   typedef struct {
      logic         wr;
      logic [W-1:0] data;
      logic [W-1:0] pad;
      int           ready_lat;
      int           first_drive;
      int           drive_cnt;
      int           rdv_lat;
      logic [W-1:0] rd;
      logic         park_oe;
      logic         dir_after;
   } vec_t;

   vec_t vecs[7];

   int           meas_wait, meas_ready, meas_first, meas_cnt, meas_badout, meas_rdv, meas_rdvn;
   logic [W-1:0] meas_rd;
   logic         meas_park, meas_dir;

   // Called at a negedge; returns at the negedge of the cycle cmd_ready is back.
   task automatic run_cmd(input logic wr, input logic [W-1:0] data, input logic [W-1:0] pad);
      cmd_valid = 1'b1; cmd_write = wr; cmd_data = data; io_in = pad;
      meas_wait = 0;
      while (!cmd_ready && meas_wait < 50) begin
         @(negedge clk);
         meas_wait++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_data = ~data;
      meas_ready = -1; meas_first = 0; meas_cnt = 0; meas_badout = 0;
      meas_rdv = 0; meas_rdvn = 0; meas_rd = '0; meas_park = 1'bx; meas_dir = 1'bx;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (rd_valid) begin
            meas_rdvn++; meas_rdv = k; meas_rd = rd_data;
         end
         if (cmd_ready) begin
            meas_ready = k; meas_park = io_oe; meas_dir = dir_tx;
            break;
         end
         if (io_oe) begin
            if (meas_first == 0) meas_first = k;
            meas_cnt++;
            if (io_out !== data) meas_badout++;
         end
      end
   endtask

   // ---------------- randomized run: cycle-schedule model ----------------
   bit           rnd_on = 1'b0;
   bit           took = 1'b0;
   int           cyc, ready_at, dir_at, drv_lo, drv_hi, rdv_at, samp_at;
   int           accepted, reads_acc, rdv_seen, low_run;
   logic         mdl_dir_prev, mdl_dir_new, prev_oe;
   logic [W-1:0] mdl_out, mdl_rd, pend_rd;

   always @(negedge clk) begin
      if (rnd_on) begin
         logic exp_ready, exp_dir, exp_oe, exp_rdv;
         int   t0;
         cyc++;
         exp_ready = (cyc >= ready_at);
         exp_dir   = (cyc >= dir_at) ? mdl_dir_new : mdl_dir_prev;
         exp_oe    = exp_ready ? exp_dir : (cyc >= drv_lo && cyc <= drv_hi);
         if (cyc == samp_at) pend_rd = io_in;
         exp_rdv = (cyc == rdv_at);
         if (exp_rdv) mdl_rd = pend_rd;

         check("rnd_cmd_ready", cmd_ready, exp_ready);
         check("rnd_busy", busy, !exp_ready);
         check("rnd_dir_tx", dir_tx, exp_dir);
         check("rnd_io_oe", io_oe, exp_oe);
         check("rnd_rd_valid", rd_valid, exp_rdv);
         check("rnd_rd_data", rd_data, mdl_rd);
         if (exp_oe) check("rnd_io_out", io_out, mdl_out);
         if (dut.state inside {ST_TURN_TX, ST_TURN_RX, ST_SAMPLE})
            check("rnd_oe_in_quiet_state", io_oe, 1'b0);
         if (io_oe && !prev_oe) check("rnd_turn_gap_ok", low_run >= TC, 1'b1);
         low_run = io_oe ? 0 : low_run + 1;
         prev_oe = io_oe;
         if (rd_valid) rdv_seen++;

         took = cmd_valid && cmd_ready;
         if (took) begin
            accepted++;
            t0 = cyc;
            if (cmd_write) begin
               drv_lo       = t0 + 1 + (exp_dir ? 0 : TC);
               drv_hi       = drv_lo + HC - 1;
               ready_at     = drv_hi + 1;
               mdl_dir_prev = exp_dir; mdl_dir_new = 1'b1; dir_at = drv_lo;
               mdl_out      = cmd_data;
            end else begin
               reads_acc++;
               rdv_at       = t0 + 1 + (exp_dir ? TC : 0) + SC;
               samp_at      = rdv_at - 1;
               ready_at     = rdv_at;
               mdl_dir_prev = exp_dir; mdl_dir_new = 1'b0; dir_at = t0 + 1;
               drv_lo       = 1; drv_hi = 0;
            end
         end
      end
   end

   initial begin
      //          wr    data    pad    rdy fst cnt rdv rd     park  dir
      vecs[0] = '{1'b1, 8'hA5, 8'h00, 6,  3,  3,  0,  8'h00, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 8'h3C, 8'h00, 4,  1,  3,  0,  8'h00, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 8'h5A, 5,  0,  0,  5,  8'h5A, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 8'h11, 3,  0,  0,  3,  8'h11, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 8'h22, 3,  0,  0,  3,  8'h22, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 8'h0F, 8'h00, 6,  3,  3,  0,  8'h00, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 8'h00, 8'hC3, 5,  0,  0,  5,  8'hC3, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_io_oe", io_oe, 1'b0);
      check("rst_io_out", io_out, 8'h00);
      check("rst_dir_tx", dir_tx, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rel_cmd_ready", cmd_ready, 1'b1);

      for (int i = 0; i < 7; i++) begin
         run_cmd(vecs[i].wr, vecs[i].data, vecs[i].pad);
         check($sformatf("v%0d_accept_wait", i), meas_wait, 0);
         check($sformatf("v%0d_ready_lat", i), meas_ready, vecs[i].ready_lat);
         check($sformatf("v%0d_first_drive", i), meas_first, vecs[i].first_drive);
         check($sformatf("v%0d_drive_cnt", i), meas_cnt, vecs[i].drive_cnt);
         check($sformatf("v%0d_io_out_bad", i), meas_badout, 0);
         check($sformatf("v%0d_rdv_lat", i), meas_rdv, vecs[i].rdv_lat);
         check($sformatf("v%0d_rdv_count", i), meas_rdvn, vecs[i].wr ? 0 : 1);
         if (!vecs[i].wr) check($sformatf("v%0d_rd_data", i), meas_rd, vecs[i].rd);
         check($sformatf("v%0d_park_oe", i), meas_park, vecs[i].park_oe);
         check($sformatf("v%0d_dir_after", i), meas_dir, vecs[i].dir_after);
      end

      // rd_data holds between reads
      io_in = 8'hEE;
      repeat (3) @(negedge clk);
      check("hold_rd_data", rd_data, 8'hC3);
      check("hold_rd_valid", rd_valid, 1'b0);

      // Asynchronous reset in the middle of a write's drive phase
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h99;
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 0; k < 20 && !io_oe; k++) @(negedge clk);
      check("mid_drive_reached", io_oe, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_io_oe", io_oe, 1'b0);
      check("mid_rst_io_out", io_out, 8'h00);
      check("mid_rst_dir_tx", dir_tx, 1'b0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rd_data", rd_data, 8'h00);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_cmd_ready", cmd_ready, 1'b1);
      for (int k = 0; k < 6; k++) begin
         check("mid_rel_no_rd_valid", rd_valid, 1'b0);
         check("mid_rel_no_oe", io_oe, 1'b0);
         @(negedge clk);
      end

      // Randomized run
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      cyc = 0; ready_at = 1; dir_at = 0; drv_lo = 1; drv_hi = 0; rdv_at = -1; samp_at = -1;
      accepted = 0; reads_acc = 0; rdv_seen = 0; low_run = TC; prev_oe = 1'b0;
      mdl_dir_prev = 1'b0; mdl_dir_new = 1'b0; mdl_out = '0; mdl_rd = '0; pend_rd = '0;
      #2 rst_n = 1'b1;
      rnd_on = 1'b1;
      for (int g = 0; g < 20000 && accepted < 500; g++) begin
         @(posedge clk); #1;
         io_in = W'($urandom);
         if (!cmd_valid || took) begin
            if ($urandom_range(0, 2) == 0) begin
               cmd_valid = 1'b0;
            end else begin
               cmd_valid = 1'b1;
               cmd_write = 1'($urandom_range(0, 1));
               cmd_data  = W'($urandom);
            end
         end
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      check("rnd_all_accepted", accepted >= 500, 1'b1);
      for (int k = 0; k < 40 && !cmd_ready; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      rnd_on = 1'b0;
      check("rnd_rd_valid_per_read", rdv_seen, reads_acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bidir_bus_sequencer.md
Name: bidir_bus_sequencer

Overview:
- Half-duplex controller for a shared tristate data pin group; sequences the output-enable and data drive of a bidirectional port.
- Host issues write/read commands over a valid/ready handshake.
- Block inserts bus-turnaround gaps on every direction change, drives write data for a fixed hold window, and samples the pad for reads.
- Sits between host logic and the top-level bidirectional pad buffer (pad = io_oe ? io_out : 'z; io_in = pad).

Parameters:
- WIDTH, 8, data width of bus and command/read data.
- TURN_CYC, 2, idle (undriven) cycles inserted on each direction change; legal range 1..15.
- HOLD_CYC, 3, cycles write data is driven per write; legal range 1..15.
- SAMPLE_CYC, 2, cycles of read settle; pad is sampled on the last one; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command (IDLE only).
- cmd_write  in  1  1 = write, 0 = read; qualified by cmd_valid.
- cmd_data  in  WIDTH  write data; qualified by cmd_valid & cmd_write.
- rd_valid  out  1  one-cycle pulse, read data available.
- rd_data  out  WIDTH  last sampled read data; holds between reads.
- io_oe  out  1  pad output enable.
- io_out  out  WIDTH  pad output data.
- io_in  in  WIDTH  pad input data, already synchronised externally.
- dir_tx  out  1  current bus ownership: 1 = block drives, 0 = released.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous assert, active low.
- Reset values:
  - State IDLE, dir_tx = 0, io_oe = 0.
  - io_out = 0, rd_data = 0, rd_valid = 0.
  - cmd_ready = 0 while rst_n is low; 1 in the first cycle after release.
- All outputs are registered.
- FSM states: IDLE, TURN_TX, DRIVE, TURN_RX, SAMPLE.
- Handshake:
  - A command is accepted on the edge where cmd_valid & cmd_ready.
  - cmd_ready = (state == IDLE).
  - Write data is latched at acceptance; cmd_data may change afterwards.
- IDLE:
  - io_oe = dir_tx. The bus stays parked driven with the last write value after a write, and undriven after a read or reset.
  - Write accepted with dir_tx=1 -> DRIVE.
  - Write accepted with dir_tx=0 -> TURN_TX.
  - Read accepted with dir_tx=0 -> SAMPLE.
  - Read accepted with dir_tx=1 -> TURN_RX.
- TURN_TX: io_oe = 0 for TURN_CYC cycles, then DRIVE; dir_tx is set on entry to DRIVE.
- DRIVE:
  - io_oe = 1 and io_out = latched data for HOLD_CYC cycles, then IDLE.
  - io_out keeps the value after DRIVE.
- TURN_RX: io_oe deasserts on entry; dir_tx clears on entry; lasts TURN_CYC cycles, then SAMPLE.
- SAMPLE:
  - io_oe = 0 for SAMPLE_CYC cycles.
  - On the final cycle's edge, rd_data <= io_in and state -> IDLE.
  - rd_valid is high for exactly the first IDLE cycle after that edge.
- Latency from acceptance edge T:
  - Write, same direction: io_oe/io_out valid in cycles T+1..T+HOLD_CYC; cmd_ready again at T+HOLD_CYC+1.
  - Write, direction change: TURN_CYC extra cycles before the first drive cycle.
  - Read, same direction: rd_valid in cycle T+SAMPLE_CYC+1.
  - Read, direction change: rd_valid in cycle T+TURN_CYC+SAMPLE_CYC+1.
- Invariant: io_oe is never 1 in the TURN_TX, TURN_RX or SAMPLE states.
- Back-to-back commands:
  - A command presented in the rd_valid cycle is accepted (IDLE).
  - The rd_valid pulse is not extended or suppressed by that acceptance.
- cmd_valid outside IDLE is ignored and not queued; the host must hold it until cmd_ready.
- Reset mid-operation: immediately io_oe = 0 and all state returns to reset values. The in-flight command is dropped and no rd_valid is produced.
- Timer: a single down-counter of 4 bits is loaded on each state entry (TURN_CYC/HOLD_CYC/SAMPLE_CYC minus 1); the state exits when the count is 0 and the state is active.

Decomposition:
- Shared package bidir_pkg holds:
  - state enum (IDLE, TURN_TX, DRIVE, TURN_RX, SAMPLE);
  - localparam CNT_W = 4;
  - range-check constants for the timing parameters.
- One sub-module, bidir_phase_timer (load value, load strobe, done flag), instantiated once and shared by all timed states.
- FSM, data latch and read capture stay in the top module.

Test Plan:
- Reset, then write 0xA5 (TURN_CYC=2, HOLD_CYC=3):
  - io_oe low for T+1..T+2, then high with io_out=0xA5 for T+3..T+5;
  - cmd_ready returns at T+6; dir_tx=1 afterwards.
- Write 0x3C immediately after the previous write: no turnaround; io_out=0x3C from T+1; io_oe never drops between the writes.
- Read with io_in=0x5A after a write:
  - io_oe falls at T+1;
  - rd_valid is a single pulse at T+5 with rd_data=0x5A;
  - rd_data holds 0x5A after the pulse.
- Read, read back-to-back with io_in changing 0x11 then 0x22: no turnaround between them; rd_data 0x11 then 0x22; second command is accepted in the first rd_valid cycle.
- Assert rst_n low during DRIVE of a write: io_oe=0 asynchronously (same cycle); all outputs at reset values; no rd_valid; cmd_ready=1 in the first cycle after release.
- Assertion run with 500 random commands and random cmd_valid gaps:
  - io_oe is never high in TURN_TX, TURN_RX or SAMPLE;
  - every direction change has ≥ TURN_CYC undriven cycles;
  - every accepted read yields exactly one rd_valid.
